// File: rtl/idli_pkg.sv
// idli_pkg: shared datapath types for the idli core (slice, slice counter, shift op).
`default_nettype none

package idli_pkg;

  typedef logic [3:0] slice_t;
  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {
    SHIFT_OP_ROR = 2'd0,
    SHIFT_OP_ROL = 2'd1,
    SHIFT_OP_SRL = 2'd2,
    SHIFT_OP_SRA = 2'd3
  } shift_op_t;

endpackage

`default_nettype wire

// File: rtl/idli_shift_if.sv
// idli_shift_if: slice bus between the execute stage and the shift unit.
// Optional o_cout signal present only when IDLI_SHIFT_COUT_EN is defined.
`default_nettype none

interface idli_shift_if;
  import idli_pkg::*;

  ctr_t      i_ctr;
  logic      i_valid;
  shift_op_t i_op;
  slice_t    i_data;
  logic      o_valid;
  slice_t    o_data;
`ifdef IDLI_SHIFT_COUT_EN
  logic      o_cout;
`endif

  modport slave (
    input  i_ctr, i_valid, i_op, i_data,
    output o_valid, o_data
`ifdef IDLI_SHIFT_COUT_EN
    , output o_cout
`endif
  );

  modport master (
    output i_ctr, i_valid, i_op, i_data,
    input  o_valid, o_data
`ifdef IDLI_SHIFT_COUT_EN
    , input o_cout
`endif
  );

endinterface

`default_nettype wire

// File: rtl/idli_shift.sv
// idli_shift: nibble-serial one-bit shift/rotate, one result per 4-cycle window.
// Optional carry-out: define IDLI_SHIFT_COUT_EN to add o_cout.
`default_nettype none

module idli_shift
  import idli_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  idli_shift_if.slave   sh
);

  logic        r_cap_vld;
  shift_op_t   r_cap_op;
  logic [11:0] r_cap;
  logic [15:0] r_res;
  logic        r_o_valid;
  slice_t      r_o_data;
  logic [15:0] w_word;
  logic [15:0] w_shift;
  ctr_t        w_nxt;
`ifdef IDLI_SHIFT_COUT_EN
  logic        r_o_cout;
  logic        w_cout;
`endif

  assign w_word = {sh.i_data, r_cap};
  assign w_nxt  = sh.i_ctr + 2'd1;

  always_comb begin
    w_shift = {w_word[0], w_word[15:1]};
    unique case (r_cap_op)
      SHIFT_OP_ROR: w_shift = {w_word[0], w_word[15:1]};
      SHIFT_OP_ROL: w_shift = {w_word[14:0], w_word[15]};
      SHIFT_OP_SRL: w_shift = {1'b0, w_word[15:1]};
      SHIFT_OP_SRA: w_shift = {w_word[15], w_word[15:1]};
      default:      w_shift = {w_word[0], w_word[15:1]};
    endcase
  end

`ifdef IDLI_SHIFT_COUT_EN
  assign w_cout = (r_cap_op == SHIFT_OP_ROL) ? w_word[15] : w_word[0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap_vld <= 1'b0;
      r_cap_op  <= SHIFT_OP_ROR;
      r_cap     <= 12'h000;
      r_res     <= 16'h0000;
      r_o_valid <= 1'b0;
      r_o_data  <= 4'h0;
`ifdef IDLI_SHIFT_COUT_EN
      r_o_cout  <= 1'b0;
`endif
    end else begin
      if (sh.i_ctr == 2'd0) begin
        r_cap_vld <= sh.i_valid;
        r_cap_op  <= sh.i_op;
      end

      case (sh.i_ctr)
        2'd0:    r_cap[3:0]  <= sh.i_data;
        2'd1:    r_cap[7:4]  <= sh.i_data;
        2'd2:    r_cap[11:8] <= sh.i_data;
        default: ;
      endcase

      // Output registers run one slice ahead of i_ctr so o_data lines up with the counter.
      if (sh.i_ctr == 2'd3) begin
        if (r_cap_vld) begin
          r_res     <= w_shift;
          r_o_valid <= 1'b1;
          r_o_data  <= w_shift[3:0];
`ifdef IDLI_SHIFT_COUT_EN
          r_o_cout  <= w_cout;
`endif
        end else begin
          r_o_valid <= 1'b0;
          r_o_data  <= 4'h0;
`ifdef IDLI_SHIFT_COUT_EN
          r_o_cout  <= 1'b0;
`endif
        end
      end else begin
        r_o_data <= r_o_valid ? r_res[{w_nxt, 2'b00} +: 4] : 4'h0;
      end
    end
  end

  assign sh.o_valid = r_o_valid;
  assign sh.o_data  = r_o_data;
`ifdef IDLI_SHIFT_COUT_EN
  assign sh.o_cout  = r_o_cout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idli_shift.sv
// tb_idli_shift: directed + randomized windows checked cycle-by-cycle against a word-level model.
`default_nettype none

module tb_idli_shift;
  import idli_pkg::*;

  localparam int NW = 48;
  localparam int NC = 4 * NW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  idli_shift_if u_if ();

  idli_shift u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .sh    (u_if.slave)
  );

  logic [3:0]  dat_a [NC];
  logic [1:0]  op_a  [NC];
  bit          vld_a [NC];
  bit          rst_a [NC];

  bit          win_ok   [NW];
  logic [15:0] win_res  [NW];
  bit          win_cout [NW];

  logic [15:0] obs_word [NW];
  int          obs_vcnt [NW];
  bit          obs_cout [NW];

  int ncmp = 0;
  int nmis = 0;

  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] w);
    case (op)
      2'd0:    return (w >> 1) | (w << 15);
      2'd1:    return (w << 1) | (w >> 15);
      2'd2:    return w >> 1;
      default: return 16'($signed(w) >>> 1);
    endcase
  endfunction

  function automatic bit ref_cout(input logic [1:0] op, input logic [15:0] w);
    return (op == 2'd1) ? w[15] : w[0];
  endfunction

  task automatic set_win(input int w, input bit v, input logic [1:0] op, input logic [15:0] d);
    for (int k = 0; k < 4; k++) begin
      dat_a[4*w+k] = d[4*k +: 4];
      vld_a[4*w+k] = v;
      op_a[4*w+k]  = op;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    ncmp++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic chk_word(input int w, input logic [15:0] exp_word, input bit exp_c);
    chk("word_vcnt", w, 16'(obs_vcnt[w]), 16'd4);
    chk("word_val", w, obs_word[w], exp_word);
`ifdef IDLI_SHIFT_COUT_EN
    chk("word_cout", w, {15'd0, obs_cout[w]}, {15'd0, exp_c});
`else
    if (exp_c === 1'bx) $display("unused");
`endif
  endtask

  // Stimulus build, model evaluation and input driving.
  initial begin
    for (int n = 0; n < NC; n++) begin
      dat_a[n] = 4'($urandom);
      op_a[n]  = 2'($urandom);
      vld_a[n] = 1'b0;
      rst_a[n] = 1'b0;
    end
    rst_a[0] = 1'b1;
    rst_a[1] = 1'b1;
    set_win(0,  1'b1, 2'd0, 16'hAAAA);
    set_win(1,  1'b1, 2'd0, 16'h8001);
    set_win(2,  1'b1, 2'd1, 16'h8001);
    set_win(3,  1'b1, 2'd2, 16'h8000);
    set_win(4,  1'b1, 2'd3, 16'h8000);
    set_win(5,  1'b1, 2'd3, 16'h7FFF);
    set_win(6,  1'b1, 2'd0, 16'h0002);
    set_win(7,  1'b1, 2'd2, 16'hFFFF);
    set_win(8,  1'b1, 2'd1, 16'h1234);
    for (int k = 1; k < 4; k++) vld_a[32+k] = 1'b0;
    set_win(9,  1'b0, 2'd0, 16'hFFFF);
    for (int k = 1; k < 4; k++) vld_a[36+k] = 1'b1;
    set_win(10, 1'b1, 2'd3, 16'h8421);
    op_a[42] = 2'd1;
    op_a[43] = 2'd1;
    set_win(11, 1'b1, 2'd0, 16'h0003);
    set_win(12, 1'b1, 2'd0, 16'hFFFF);
    rst_a[50] = 1'b1;
    set_win(13, 1'b1, 2'd1, 16'h0F0F);
    for (int w = 14; w < NW - 1; w++) begin
      set_win(w, ($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom));
      for (int k = 1; k < 4; k++) begin
        vld_a[4*w+k] = 1'($urandom);
        op_a[4*w+k]  = 2'($urandom);
      end
      for (int k = 0; k < 4; k++)
        if (4*w+k >= 60 && $urandom_range(0, 39) == 0) rst_a[4*w+k] = 1'b1;
    end

    for (int w = 0; w < NW; w++) begin
      logic [15:0] word;
      word = {dat_a[4*w+3], dat_a[4*w+2], dat_a[4*w+1], dat_a[4*w]};
      win_ok[w] = vld_a[4*w];
      for (int k = 0; k < 4; k++) if (rst_a[4*w+k]) win_ok[w] = 1'b0;
      win_res[w]  = ref_shift(op_a[4*w], word);
      win_cout[w] = ref_cout(op_a[4*w], word);
      obs_word[w] = 16'h0;
      obs_vcnt[w] = 0;
      obs_cout[w] = 1'b0;
    end

    for (int n = 0; n < NC; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      rst          = rst_a[n];
      u_if.i_ctr   = 2'(n % 4);
      u_if.i_valid = vld_a[n];
      u_if.i_op    = shift_op_t'(op_a[n]);
      u_if.i_data  = dat_a[n];
    end
  end

  // Per-cycle compare on the falling edge, then literal pins and summary.
  initial begin
    for (int m = 1; m < NC; m++) begin
      int  w, k;
      bit  alive;
      logic [3:0] exp_d;
      bit  exp_c;
      @(negedge clk);
      w = m / 4 - 1;
      k = m % 4;
      alive = (w >= 0) && win_ok[w];
      if (w >= 0)
        for (int j = 4*w + 4; j < m; j++) if (rst_a[j]) alive = 1'b0;
      exp_d = alive ? win_res[w][4*k +: 4] : 4'h0;
      exp_c = alive ? win_cout[w] : 1'b0;
      chk("o_valid", m, {15'd0, u_if.o_valid}, {15'd0, alive});
      chk("o_data", m, {12'd0, u_if.o_data}, {12'd0, exp_d});
`ifdef IDLI_SHIFT_COUT_EN
      chk("o_cout", m, {15'd0, u_if.o_cout}, {15'd0, exp_c});
`endif
      if (w >= 0) begin
        obs_word[w][4*k +: 4] = u_if.o_data;
        if (u_if.o_valid === 1'b1) obs_vcnt[w]++;
`ifdef IDLI_SHIFT_COUT_EN
        if (k == 0) obs_cout[w] = u_if.o_cout;
`endif
      end
    end

    chk_word(1,  16'hC000, 1'b1);
    chk_word(2,  16'h0003, 1'b1);
    chk_word(3,  16'h4000, 1'b0);
    chk_word(4,  16'hC000, 1'b0);
    chk_word(5,  16'h3FFF, 1'b1);
    chk_word(6,  16'h0001, 1'b0);
    chk_word(7,  16'h7FFF, 1'b1);
    chk_word(8,  16'h2468, 1'b0);
    chk_word(10, 16'hC210, 1'b1);
    chk_word(13, 16'h1E1E, 1'b0);
    chk("idle_vcnt", 0,  16'(obs_vcnt[0]),  16'd0);
    chk("idle_vcnt", 9,  16'(obs_vcnt[9]),  16'd0);
    chk("idle_data", 9,  obs_word[9],       16'h0000);
    chk("rst_vcnt",  11, 16'(obs_vcnt[11]), 16'd3);
    chk("rst_vcnt",  12, 16'(obs_vcnt[12]), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule

`default_nettype wire
